instr_queue_param: RTL
======================

Name: instr_queue_param

Overview:
- Parametrised successor to the fetch-side instruction queue. Sits between the fetcher and the decoder.
- Buffers fetched instructions together with their PCs in a circular FIFO.
- Drives the next fetch PC to the fetcher and presents the head entry to the decoder with a valid/ready handshake.
- Adds PC-tagged response filtering, an occupancy count, an almost-full flag and a ROB redirect flush.

Parameters:
- DEPTH_LOG2, 4, log2 of the entry count (DEPTH = 2**DEPTH_LOG2; legal 1..6).
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, PC width in bits.
- PC_STEP, 4, byte increment between sequential instructions.
- AFULL_TH, 2, free-entry count at or below which almost_full asserts.
- RESET_PC, 0, value of tail_pc after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- is_exception_from_rob  in  1  flush/redirect strobe.
- pc_from_rob  in  PC_W  redirect target, valid with the flush strobe.
- is_hit_from_fetcher  in  1  fetch response valid.
- instr_from_fetcher  in  INSTR_W  fetched instruction.
- pc_from_fetcher  in  PC_W  PC the response belongs to.
- pc_to_fetcher  out  PC_W  next PC to fetch (tail_pc).
- fetch_req_to_fetcher  out  1  queue will accept a response for pc_to_fetcher.
- is_stall_from_rs  in  1  RS cannot accept.
- is_stall_from_rob  in  1  ROB cannot accept.
- is_empty_to_decoder  out  1  1 = no valid head entry.
- instr_to_decoder  out  INSTR_W  head instruction.
- pc_to_decoder  out  PC_W  head PC.
- count  out  DEPTH_LOG2+1  current occupancy.
- almost_full  out  1  (DEPTH - count) <= AFULL_TH.

Behaviour:
- Storage: DEPTH entries of {instr, pc}.
- head_ptr and tail_ptr are DEPTH_LOG2+1 bits; the MSB is a wrap bit.
  - empty when head_ptr == tail_ptr.
  - full when indices are equal and wrap bits differ.
  - count = tail_ptr - head_ptr, modulo 2**(DEPTH_LOG2+1).
- Reset (rst low, asynchronous):
  - Pointers = 0, tail_pc = RESET_PC, count = 0, almost_full = 0 (AFULL_TH < DEPTH).
  - is_empty_to_decoder = 1, instr_to_decoder = 0, pc_to_decoder = 0, fetch_req_to_fetcher = 0.
  - Storage contents are don't-care.
  - Deassertion of reset takes effect at the first clk edge with rst high.
- fetch_req_to_fetcher = !full && !is_exception_from_rob && rst. This is combinational.
- Enqueue accept: is_hit_from_fetcher && !full && pc_from_fetcher == tail_pc && !is_exception_from_rob.
  - On accept: write {instr_from_fetcher, tail_pc} at tail index; tail_ptr += 1; tail_pc += PC_STEP, wrapping modulo 2**PC_W.
  - A hit that fails any accept term is silently dropped and tail_pc holds, so the fetcher refetches the same PC.
- Dequeue:
  - ready = !is_stall_from_rs && !is_stall_from_rob.
  - fire = !empty && ready && !is_exception_from_rob.
  - On fire: head_ptr += 1.
- Decoder outputs are combinational from registered state.
  - When not empty: is_empty_to_decoder = 0, instr/pc_to_decoder = entry at head index.
  - When empty: is_empty_to_decoder = 1, instr/pc = 0.
  - The decoder consumes the head on any cycle with is_empty_to_decoder = 0 and ready = 1.
- Latency: an accepted response is visible to the decoder the cycle after acceptance (one-cycle enqueue-to-head latency).
- Simultaneous enqueue and dequeue:
  - Both take effect; count is unchanged.
  - When full, enqueue is refused even if a dequeue fires the same cycle; no full-bypass.
- Flush (is_exception_from_rob = 1 at an edge):
  - head_ptr = tail_ptr = 0; tail_pc = pc_from_rob.
  - Flush overrides any same-cycle enqueue and dequeue.
  - is_empty_to_decoder = 1 from the next cycle.
  - Stale in-flight responses arriving later are rejected by the PC tag compare.
- count and almost_full are combinational from the pointers.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined: when the queue is empty, ready = 1, the enqueue accept condition holds and there is no flush, the response passes combinationally to the decoder outputs in the same cycle. is_empty_to_decoder = 0, instr/pc come from the fetcher, and no entry is written. tail_pc still advances.
- Undefined: there is no bypass and the minimum latency is one cycle.

Test Plan:
- Reset: rst = 0 mid-run with count = 5 -> outputs go to reset values immediately; after release pc_to_fetcher = RESET_PC (0), count = 0.
- Fill: hits with pc 0,4,...,60 and decoder stalled -> count = 16, full, fetch_req = 0, almost_full from count 14. A 17th hit with pc 64 is dropped and pc_to_fetcher stays 64.
- Drain: stalls released -> decoder sees pc 0..60 in order, one per cycle, instr matching. is_empty_to_decoder = 1 after the 16th.
- Tag filter: hit with pc_from_fetcher = 8 while tail_pc = 4 -> dropped; count and tail_pc unchanged.
- Flush collision: flush with pc_from_rob = 0x100 plus a valid hit and a dequeue in the same cycle -> count = 0, pc_to_fetcher = 0x100. A later hit with pc 0x40 is dropped; a hit with pc 0x100 is accepted.
- Pointer wrap: 40 continuous enqueue/dequeue pairs at count = 3 -> count is constant at 3 and PCs come out strictly sequential across the index wrap. With IQ_BYPASS_EN, a hit on an empty queue with ready = 1 appears on the decoder in the same cycle.

Source files
------------

// File: rtl/instr_queue_param.sv
// Fetch-side instruction queue: circular FIFO of {instr, pc} with PC-tag filtering,
// occupancy/almost-full reporting and ROB flush. Define IQ_BYPASS_EN for same-cycle empty bypass.
`timescale 1ns/1ps
module instr_queue_param #(
    parameter int unsigned     DEPTH_LOG2 = 4,
    parameter int unsigned     INSTR_W    = 32,
    parameter int unsigned     PC_W       = 32,
    parameter int unsigned     PC_STEP    = 4,
    parameter int unsigned     AFULL_TH   = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_exception_from_rob,
    input  logic [PC_W-1:0]       pc_from_rob,
    input  logic                  is_hit_from_fetcher,
    input  logic [INSTR_W-1:0]    instr_from_fetcher,
    input  logic [PC_W-1:0]       pc_from_fetcher,
    output logic [PC_W-1:0]       pc_to_fetcher,
    output logic                  fetch_req_to_fetcher,
    input  logic                  is_stall_from_rs,
    input  logic                  is_stall_from_rob,
    output logic                  is_empty_to_decoder,
    output logic [INSTR_W-1:0]    instr_to_decoder,
    output logic [PC_W-1:0]       pc_to_decoder,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [INSTR_W-1:0]    instr_mem [DEPTH];
    logic [PC_W-1:0]       pc_mem    [DEPTH];

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PC_W-1:0]       tail_pc_q, tail_pc_d;
    logic [DEPTH_LOG2-1:0] head_idx, tail_idx;
    logic [PTR_W:0]        free_cnt;
    logic                  empty, full, ready, accept, fire, bypass, wr_en;

    assign head_idx = head_q[DEPTH_LOG2-1:0];
    assign tail_idx = tail_q[DEPTH_LOG2-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

    assign count       = tail_q - head_q;
    assign free_cnt    = (PTR_W+1)'(DEPTH) - {1'b0, count};
    assign almost_full = (free_cnt <= (PTR_W+1)'(AFULL_TH));

    assign ready  = !is_stall_from_rs && !is_stall_from_rob;
    // The PC tag compare is what discards responses fetched before a redirect.
    assign accept = is_hit_from_fetcher && !full && (pc_from_fetcher == tail_pc_q)
                    && !is_exception_from_rob;
    assign fire   = !empty && ready && !is_exception_from_rob;

`ifdef IQ_BYPASS_EN
    assign bypass = empty && ready && accept;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en                = accept && !bypass;
    assign pc_to_fetcher        = tail_pc_q;
    assign fetch_req_to_fetcher = !full && !is_exception_from_rob && rst;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        tail_pc_d = tail_pc_q;
        if (is_exception_from_rob) begin
            head_d    = '0;
            tail_d    = '0;
            tail_pc_d = pc_from_rob;
        end else begin
            if (accept) begin
                tail_pc_d = tail_pc_q + PC_W'(PC_STEP);
                if (!bypass) begin
                    tail_d = tail_q + PTR_W'(1);
                end
            end
            if (fire) begin
                head_d = head_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            tail_pc_q <= RESET_PC;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            tail_pc_q <= tail_pc_d;
        end
    end

    // Storage holds data only; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[tail_idx] <= instr_from_fetcher;
            pc_mem[tail_idx]    <= tail_pc_q;
        end
    end

    always_comb begin
        is_empty_to_decoder = 1'b1;
        instr_to_decoder    = '0;
        pc_to_decoder       = '0;
        if (!empty) begin
            is_empty_to_decoder = 1'b0;
            instr_to_decoder    = instr_mem[head_idx];
            pc_to_decoder       = pc_mem[head_idx];
        end else if (bypass && rst) begin
            is_empty_to_decoder = 1'b0;
            instr_to_decoder    = instr_from_fetcher;
            pc_to_decoder       = pc_from_fetcher;
        end
    end

endmodule
